hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller sitting between the instruction decoder and the ID/EX pipeline register. It tracks the destination registers of in-flight instructions in a shift-register scoreboard. It stalls the fetch/decode stages on read-after-write hazards, inserts bubbles into EX, and flushes the wrong-path instruction when EX resolves a taken branch or jump. It also keeps a saturating stall-cycle counter for performance debug.

## Interface

Parameters:
- REGISTER_ADDR_WIDTH, 5: register address width, matching the decoder.
- DEPTH, 3: number of pipeline stages after ID whose result is not yet readable by ID (EX, MEM, WB). Legal range 1..4.
- CNT_WIDTH, 16: width of the stall counter.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- id_valid, input, 1: ID holds a real instruction; 0 after flush or at start-up.
- id_RW, input, 1: decoder RW for the ID instruction.
- id_DA, input, REGISTER_ADDR_WIDTH: decoder DA.
- id_AA, input, REGISTER_ADDR_WIDTH: decoder AA.
- id_BA, input, REGISTER_ADDR_WIDTH: decoder BA.
- id_MA, input, 1: 1 means port A is not a register read (PC used).
- id_MB, input, 1: 1 means port B is not a register read (constant used).
- id_MD, input, 2: decoder MD; 2'b01 marks a load.
- ex_branch_taken, input, 1: the EX instruction redirects the PC this cycle (BZ/BNZ taken, JMR, JMP, JML).
- stall, output, 1: hold PC and the IF/ID register.
- bubble, output, 1: load NOP controls into ID/EX (RW=0, MW=0, BS=0).
- flush, output, 1: invalidate the IF/ID register.
- stall_count, output, CNT_WIDTH: number of cycles with stall=1, saturating.

## Operation

- Scoreboard: DEPTH entries, each holding {wr, dst, ld}. Entry 0 is the instruction in EX and entry DEPTH-1 is the oldest.
- issue = id_valid & ~stall & ~flush.
- Every cycle, entries shift: entry[k+1] <= entry[k].
- entry[0] <= issue ? {id_RW & (id_DA != 0), id_DA, id_MD == 2'b01} : {0, 0, 0}.
- Register 0 is never a hazard source, as a destination or as a source.
- Source A is read when id_MA == 0 and id_AA != 0. Source B is read when id_MB == 0 and id_BA != 0.
- Stores read BA through the MB=0 path, so this rule covers them too.
- A match for entry k is: entry[k].wr and entry[k].dst equals a read source.
- hazard = id_valid & (any match, subject to the FORWARD_EN rule under Configuration).
- Priority when ex_branch_taken=1:
  - flush=1, bubble=1, stall=0, overriding any hazard.
  - The ID instruction is wrong-path and is killed; it never enters the scoreboard.
  - Entry 0 is the branch itself and is retained, so JML link writes still count.
- Otherwise: stall = hazard, bubble = hazard, flush = 0.
- stall, bubble and flush are combinational from the current inputs and scoreboard state.
- stall_count increments when stall=1 and holds at all ones once reached.
- No stall may last longer than DEPTH consecutive cycles, because every stall shifts in an invalid entry.

## Timing

- Reset (rst_n=0 at a rising edge): all entries cleared and stall_count=0.
- While rst_n=0, stall, bubble and flush are forced to 0.
- The first cycle after reset has no hazard regardless of ID contents.
- Hazard detection has zero-cycle latency: stall is valid in the same cycle as the ID inputs.
- Stall length without forwarding = DEPTH - k for a producer at entry k. For example, a back-to-back dependent pair with DEPTH=3 gives 3 stall cycles.
- A branch taken in the same cycle as a hazard produces no stall, and stall_count does not increment.
- Reset asserted mid-stall clears the scoreboard at that edge. The next cycle after release issues without stalling.

## Configuration

- HAZARD_CTRL_FORWARD_EN defined: the datapath forwards EX/MEM/WB results.
  - Only load-use stalls: a match on entry 0 with entry[0].ld=1.
  - Matches on entries 1..DEPTH-1, and on non-load entry 0, do not stall.
- HAZARD_CTRL_FORWARD_EN undefined: every match on any entry stalls.

## Test plan

- No forwarding, DEPTH=3: ADD R1←R2,R3 then ADD R4←R1,R5 → stall=1 for exactly 3 cycles, 3 bubbles, then the second instruction issues; stall_count=3.
- AA=R1 with id_MA=1 and BA=R1 with id_MB=1 (e.g. ADI) after a write to R1 → no stall for the MA-masked A port, no stall for the MB-masked B port; R0 as destination or source → never stall.
- HAZARD_CTRL_FORWARD_EN: LD R1 then ADD R2←R1,R3 → exactly 1 stall cycle. ADD R1 then ADD using R1 → 0 stalls.
- Hazard pending and ex_branch_taken=1 in the same cycle → flush=1, bubble=1, stall=0; stall_count unchanged; the killed instruction's DA does not cause later stalls.
- rst_n=0 for one cycle during the second cycle of a 3-cycle stall → outputs 0 during reset; after release, the dependent instruction issues with stall=0; stall_count=0.
- CNT_WIDTH=4 with 20 forced stall cycles → stall_count saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller placed between the instruction decoder and the
// ID/EX pipeline register. A shift-register scoreboard records the destination
// register of every instruction that has left ID but whose result ID cannot
// read yet. From this scoreboard the block:
//   - stalls fetch/decode on read-after-write hazards,
//   - inserts bubbles into EX while stalling,
//   - flushes the wrong-path instruction in ID when EX redirects the PC.
// It also keeps a saturating count of stalled cycles for performance debug.
//
// Optional feature macro: HAZARD_CTRL_FORWARD_EN
//   defined   : the datapath forwards EX/MEM/WB results, so only a load in EX
//               feeding the ID instruction (load-use) stalls.
//   undefined : any match against any scoreboard entry stalls.
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   synchronous active-low reset
//   id_valid        in   ID holds a real instruction
//   id_RW           in   ID instruction writes the register file
//   id_DA           in   ID destination register
//   id_AA, id_BA    in   ID source registers A and B
//   id_MA           in   1: port A uses the PC, not a register
//   id_MB           in   1: port B uses a constant, not a register
//   id_MD           in   result select, 2'b01 marks a load
//   ex_branch_taken in   EX instruction redirects the PC this cycle
//   stall           out  hold PC and IF/ID register (combinational)
//   bubble          out  load NOP controls into ID/EX (combinational)
//   flush           out  invalidate IF/ID register (combinational)
//   stall_count     out  saturating number of stalled cycles (registered)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int DEPTH               = 3,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid,
    input  logic                           id_RW,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_DA,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_AA,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_BA,
    input  logic                           id_MA,
    input  logic                           id_MB,
    input  logic [1:0]                     id_MD,
    input  logic                           ex_branch_taken,
    output logic                           stall,
    output logic                           bubble,
    output logic                           flush,
    output logic [CNT_WIDTH-1:0]           stall_count
);

    localparam logic [REGISTER_ADDR_WIDTH-1:0] REG_ZERO = {REGISTER_ADDR_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]           CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]           CNT_ONE  = CNT_WIDTH'(1);

    // Scoreboard: index 0 is the instruction in EX, DEPTH-1 the oldest.
    logic [DEPTH-1:0]               wr_q;
    logic [DEPTH-1:0]               wr_d;
    logic [DEPTH-1:0]               ld_q;
    logic [DEPTH-1:0]               ld_d;
    logic [REGISTER_ADDR_WIDTH-1:0] dst_q [DEPTH];
    logic [REGISTER_ADDR_WIDTH-1:0] dst_d [DEPTH];
    logic [CNT_WIDTH-1:0]           stall_count_q;
    logic [CNT_WIDTH-1:0]           stall_count_d;

    logic             rd_a_s;
    logic             rd_b_s;
    logic [DEPTH-1:0] match_s;
    logic             hazard_s;
    logic             stall_s;
    logic             bubble_s;
    logic             flush_s;
    logic             issue_s;
    // Only entry 0's load flag ever influences a decision; the older copies
    // exist so the flag travels with its instruction.
    logic             unused_ld_s;

    assign unused_ld_s = ^ld_q;

    // Hazard detection against every scoreboard entry.
    always_comb begin
        rd_a_s  = ~id_MA & (id_AA != REG_ZERO);
        rd_b_s  = ~id_MB & (id_BA != REG_ZERO);
        match_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = wr_q[k] & ((rd_a_s & (dst_q[k] == id_AA)) |
                                    (rd_b_s & (dst_q[k] == id_BA)));
        end
`ifdef HAZARD_CTRL_FORWARD_EN
        // Forwarding covers everything except a load still in EX.
        hazard_s = id_valid & match_s[0] & ld_q[0];
`else
        hazard_s = id_valid & (|match_s);
`endif
    end

    // Control outputs: a taken branch overrides any hazard; reset silences all.
    always_comb begin
        if (!rst_n) begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
            flush_s  = 1'b0;
        end else if (ex_branch_taken) begin
            stall_s  = 1'b0;
            bubble_s = 1'b1;
            flush_s  = 1'b1;
        end else begin
            stall_s  = hazard_s;
            bubble_s = hazard_s;
            flush_s  = 1'b0;
        end
        issue_s = id_valid & ~stall_s & ~flush_s;
    end

    // Next scoreboard state: shift toward the oldest slot, new entry at 0.
    always_comb begin
        wr_d  = wr_q;
        ld_d  = ld_q;
        dst_d = dst_q;
        for (int k = 1; k < DEPTH; k++) begin
            wr_d[k]  = wr_q[k-1];
            ld_d[k]  = ld_q[k-1];
            dst_d[k] = dst_q[k-1];
        end
        if (issue_s) begin
            wr_d[0]  = id_RW & (id_DA != REG_ZERO);
            dst_d[0] = id_DA;
            ld_d[0]  = (id_MD == 2'b01);
        end else begin
            // Stalled, flushed or empty ID shifts in an invalid entry, which
            // bounds every stall to DEPTH cycles.
            wr_d[0]  = 1'b0;
            dst_d[0] = REG_ZERO;
            ld_d[0]  = 1'b0;
        end
    end

    // Next stall counter value, saturating at all ones.
    always_comb begin
        if (stall_s && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q          <= {DEPTH{1'b0}};
            ld_q          <= {DEPTH{1'b0}};
            stall_count_q <= {CNT_WIDTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k] <= REG_ZERO;
            end
        end else begin
            wr_q          <= wr_d;
            ld_q          <= ld_d;
            stall_count_q <= stall_count_d;
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k] <= dst_d[k];
            end
        end
    end

    assign stall       = stall_s;
    assign bubble      = bubble_s;
    assign flush       = flush_s;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed testbench for hazard_ctrl (DEPTH=3). A second instance with a
// 4-bit counter shares all inputs and exercises counter saturation.
// Expected stall lengths follow from the producer's scoreboard position and
// from whether HAZARD_CTRL_FORWARD_EN is defined.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int DEPTH = 3;
`ifdef HAZARD_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_RW;
    logic [4:0]  id_DA;
    logic [4:0]  id_AA;
    logic [4:0]  id_BA;
    logic        id_MA;
    logic        id_MB;
    logic [1:0]  id_MD;
    logic        ex_branch_taken;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [15:0] stall_count;
    logic        s_stall;
    logic        s_bubble;
    logic        s_flush;
    logic [3:0]  s_count;

    int checks;
    int errors;
    int exp_cnt;

    hazard_ctrl #(.REGISTER_ADDR_WIDTH(5), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_RW(id_RW),
        .id_DA(id_DA), .id_AA(id_AA), .id_BA(id_BA), .id_MA(id_MA),
        .id_MB(id_MB), .id_MD(id_MD), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .bubble(bubble), .flush(flush), .stall_count(stall_count)
    );

    hazard_ctrl #(.REGISTER_ADDR_WIDTH(5), .DEPTH(DEPTH), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_RW(id_RW),
        .id_DA(id_DA), .id_AA(id_AA), .id_BA(id_BA), .id_MA(id_MA),
        .id_MB(id_MB), .id_MD(id_MD), .ex_branch_taken(ex_branch_taken),
        .stall(s_stall), .bubble(s_bubble), .flush(s_flush), .stall_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an ID instruction and let the combinational outputs settle.
    task automatic set_id(input logic v, input logic rw, input logic [4:0] da,
                          input logic [4:0] aa, input logic [4:0] ba,
                          input logic ma, input logic mb, input logic [1:0] md);
        id_valid = v;
        id_RW    = rw;
        id_DA    = da;
        id_AA    = aa;
        id_BA    = ba;
        id_MA    = ma;
        id_MB    = mb;
        id_MD    = md;
        #1;
    endtask

    // Empty ID long enough for the scoreboard to drain.
    task automatic drain();
        set_id(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00);
        repeat (DEPTH) tick();
    endtask

    // Producer writing R1, 'gap' unrelated instructions, then a reader of R1;
    // expect stall high for exactly exp_n cycles, then the reader issues.
    task automatic dep_gap(input string tag, input logic [1:0] pmd, input int gap, input int exp_n);
        set_id(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, pmd);
        tick();
        for (int g = 0; g < gap; g++) begin
            set_id(1'b1, 1'b1, 5'd7, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00);
            tick();
        end
        set_id(1'b1, 1'b1, 5'd4, 5'd1, 5'd5, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i <= exp_n; i++) begin
            check_eq({tag, "_stall"}, {31'd0, stall}, {31'd0, (i < exp_n)});
            check_eq({tag, "_bubble"}, {31'd0, bubble}, {31'd0, (i < exp_n)});
            if (i < exp_n) tick();
        end
        check_eq({tag, "_flush"}, {31'd0, flush}, 32'd0);
        exp_cnt += exp_n;
        tick();
        drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int obs_stalls;
        int bound;
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;

        // Reset with a taken branch and hazard-looking ID: outputs stay low.
        rst_n           = 1'b0;
        ex_branch_taken = 1'b1;
        set_id(1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, 2'b01);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_bubble", {31'd0, bubble}, 32'd0);
        check_eq("rst_flush", {31'd0, flush}, 32'd0);
        tick();
        tick();
        check_eq("rst_count", {16'd0, stall_count}, 32'd0);
        check_eq("rst_sat_count", {28'd0, s_count}, 32'd0);

        // First cycle after reset: no hazard whatever ID reads.
        rst_n           = 1'b1;
        ex_branch_taken = 1'b0;
        set_id(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 2'b00);
        check_eq("first_cycle_stall", {31'd0, stall}, 32'd0);
        tick();
        drain();

        // RAW distance sweep for ALU and load producers.
        dep_gap("raw_adj", 2'b00, 0, FWD ? 0 : 3);
        check_eq("raw_adj_count", {16'd0, stall_count}, exp_cnt);
        dep_gap("raw_gap1", 2'b00, 1, FWD ? 0 : 2);
        dep_gap("raw_gap2", 2'b00, 2, FWD ? 0 : 1);
        dep_gap("load_use", 2'b01, 0, FWD ? 1 : 3);
        dep_gap("load_gap1", 2'b01, 1, FWD ? 0 : 2);
        check_eq("sweep_count", {16'd0, stall_count}, exp_cnt);

        // Masked ports do not read registers.
        set_id(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00);
        tick();
        set_id(1'b1, 1'b1, 5'd6, 5'd1, 5'd7, 1'b1, 1'b0, 2'b00);
        check_eq("mask_a_stall", {31'd0, stall}, 32'd0);
        tick();
        set_id(1'b1, 1'b1, 5'd8, 5'd7, 5'd1, 1'b0, 1'b1, 2'b00);
        check_eq("mask_b_stall", {31'd0, stall}, 32'd0);
        tick();
        drain();

        // R0 is never a hazard.
        set_id(1'b1, 1'b1, 5'd0, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00);
        tick();
        set_id(1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00);
        check_eq("r0_stall", {31'd0, stall}, 32'd0);
        tick();
        drain();

        // Taken branch with a pending hazard: flush wins, counter holds.
        set_id(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b01);
        tick();
        ex_branch_taken = 1'b1;
        set_id(1'b1, 1'b1, 5'd9, 5'd1, 5'd5, 1'b0, 1'b0, 2'b00);
        check_eq("br_flush", {31'd0, flush}, 32'd1);
        check_eq("br_bubble", {31'd0, bubble}, 32'd1);
        check_eq("br_stall", {31'd0, stall}, 32'd0);
        tick();
        check_eq("br_count", {16'd0, stall_count}, exp_cnt);
        ex_branch_taken = 1'b0;
        set_id(1'b1, 1'b0, 5'd0, 5'd9, 5'd9, 1'b0, 1'b0, 2'b00);
        check_eq("killed_da_stall", {31'd0, stall}, 32'd0);
        check_eq("killed_da_flush", {31'd0, flush}, 32'd0);
        check_eq("killed_da_bubble", {31'd0, bubble}, 32'd0);
        tick();
        drain();

        // Reset asserted in the middle of a load-use stall.
        set_id(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b01);
        tick();
        set_id(1'b1, 1'b1, 5'd4, 5'd1, 5'd5, 1'b0, 1'b0, 2'b00);
        check_eq("pre_rst_stall", {31'd0, stall}, 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("mid_rst_bubble", {31'd0, bubble}, 32'd0);
        check_eq("mid_rst_flush", {31'd0, flush}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        exp_cnt = 0;
        check_eq("post_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("post_rst_count", {16'd0, stall_count}, 32'd0);
        check_eq("post_rst_sat_count", {28'd0, s_count}, 32'd0);
        tick();
        drain();

        // Accumulate at least 20 stall cycles via repeated load-use pairs.
        obs_stalls = 0;
        for (int it = 0; it < 30 && obs_stalls < 20; it++) begin
            set_id(1'b1, 1'b1, 5'd1, 5'd3, 5'd3, 1'b0, 1'b0, 2'b01);
            tick();
            set_id(1'b1, 1'b1, 5'd2, 5'd1, 5'd3, 1'b0, 1'b0, 2'b00);
            bound = 0;
            while (stall && bound < 8) begin
                obs_stalls++;
                bound++;
                tick();
            end
            tick();
        end
        drain();
        check_eq("sat_enough_stalls", {31'd0, (obs_stalls >= 20)}, 32'd1);
        check_eq("full_count", {16'd0, stall_count}, obs_stalls);
        check_eq("sat_count", {28'd0, s_count}, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
